// File: rtl/pix28_cfg_shift_ctrl.sv
// Serial configuration shifter for the pix28 chip: shifts an N-bit payload MSB first,
// captures readback on each rising scan_clk, then pulses the load strobe.
module pix28_cfg_shift_ctrl #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 64
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_word,
   output logic [C_S_AXI_DATA_WIDTH-1:0] status_word,
   output logic                          scan_clk,
   output logic                          scan_din,
   output logic                          scan_load,
   input  logic                          scan_dout,
   output logic                          busy
);

   localparam int unsigned PAYLOAD_W = 32;
   localparam int unsigned DIV_W     = 8;
   localparam int unsigned IDX_W     = 5;
   localparam int unsigned TXN_W     = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LOAD     = 2'd3
   } state_t;

   state_t               state_q;
   logic                 start_q;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [PAYLOAD_W-1:0] capture_q;
   logic [DIV_W-1:0]     div_q;
   logic [DIV_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [TXN_W-1:0]     txn_q;
   logic                 busy_q;
   logic                 clk_q;
   logic                 din_q;
   logic                 load_q;
   logic                 done_q;
   logic                 aborted_q;

   logic                 start_c;
   logic                 abort_c;
   logic                 cnt_end_c;
   logic [PAYLOAD_W-1:0] cfg_payload_c;
   logic [IDX_W-1:0]     cfg_nm1_c;
   logic                 unused_c;

   assign cfg_payload_c = cfg_word[63:32];
   assign cfg_nm1_c     = cfg_word[20:16];
   assign start_c       = cfg_word[0] & ~start_q;
   assign abort_c       = cfg_word[1];
   assign cnt_end_c     = (cnt_q == div_q);
   assign unused_c      = ^{cfg_word[31:21], cfg_word[7:2]};

   // Each shift phase lasts div_q+1 cycles; cnt_q restarts at every state change.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q   <= IDLE;
         start_q   <= 1'b1;
         payload_q <= '0;
         capture_q <= '0;
         div_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         txn_q     <= '0;
         busy_q    <= 1'b0;
         clk_q     <= 1'b0;
         din_q     <= 1'b0;
         load_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         start_q <= cfg_word[0];
         cnt_q   <= cnt_q + DIV_W'(1);
         if ((state_q != IDLE) && abort_c) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            clk_q     <= 1'b0;
            din_q     <= 1'b0;
            load_q    <= 1'b0;
            aborted_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  if (start_c) begin
                     state_q   <= SHIFT_LO;
                     payload_q <= cfg_payload_c;
                     div_q     <= cfg_word[15:8];
                     idx_q     <= cfg_nm1_c;
                     capture_q <= '0;
                     done_q    <= 1'b0;
                     aborted_q <= 1'b0;
                     busy_q    <= 1'b1;
                     clk_q     <= 1'b0;
                     din_q     <= cfg_payload_c[cfg_nm1_c];
                  end
               end
               SHIFT_LO: begin
                  if (cnt_end_c) begin
                     state_q   <= SHIFT_HI;
                     cnt_q     <= '0;
                     clk_q     <= 1'b1;
                     capture_q <= {capture_q[PAYLOAD_W-2:0], scan_dout};
                  end
               end
               SHIFT_HI: begin
                  if (cnt_end_c) begin
                     cnt_q <= '0;
                     clk_q <= 1'b0;
                     if (idx_q != '0) begin
                        state_q <= SHIFT_LO;
                        idx_q   <= idx_q - IDX_W'(1);
                        din_q   <= payload_q[idx_q - IDX_W'(1)];
                     end else begin
                        state_q <= LOAD;
                        din_q   <= 1'b0;
                        load_q  <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  if (cnt_end_c) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     load_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     txn_q   <= txn_q + TXN_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy        = busy_q;
   assign scan_clk    = clk_q;
   assign scan_din    = din_q;
   assign scan_load   = load_q;
   assign status_word = {capture_q, 11'd0, idx_q, txn_q, 5'd0, aborted_q, done_q, busy_q};

endmodule

// File: tb/tb_pix28_cfg_shift_ctrl.sv
// Scoreboard bench for pix28_cfg_shift_ctrl: expected transactions are queued at start
// and compared by a monitor when busy falls.
module tb_pix28_cfg_shift_ctrl;

   localparam int unsigned LIMIT = 5000;

   typedef struct {
      bit          is_abort;
      int          busy_len;
      logic [31:0] bits;
      int          pulses;
      int          hi;
      int          ld;
      logic [63:0] status;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [63:0] cfg_word = '0;
   logic [63:0] status_word;
   logic        scan_clk, scan_din, scan_load, scan_dout, busy;

   int          n_chk = 0;
   int          n_err = 0;
   int          dout_mode = 1;   // 0: tied 0, 1: tied 1, 2: loopback
   logic [7:0]  exp_txn = '0;
   exp_t        sb_q[$];

   assign scan_dout = (dout_mode == 2) ? scan_din : (dout_mode == 1);

   pix28_cfg_shift_ctrl #(.C_S_AXI_DATA_WIDTH(64)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .cfg_word      (cfg_word),
      .status_word   (status_word),
      .scan_clk      (scan_clk),
      .scan_din      (scan_din),
      .scan_load     (scan_load),
      .scan_dout     (scan_dout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Drive a start edge and queue what the transaction must produce.
   // mode 0: normal, 1: abort set together with start, 2: expect abort after ab_len, 3: no queue
   task automatic start_txn(input logic [31:0] pl, input logic [4:0] nm1, input logic [7:0] dv,
                            input int mode, input int ab_len);
      exp_t        e;
      int          n = int'(nm1) + 1;
      int          h = int'(dv) + 1;
      logic [31:0] mask = 32'((64'd1 << n) - 64'd1);
      logic [31:0] cap;
      @(negedge clk);
      cfg_word = {pl, 11'd0, nm1, dv, 6'd0, 1'b0, 1'b0};
      @(negedge clk);
      cfg_word[0] = 1'b1;
      cfg_word[1] = (mode == 1);
      cap = (dout_mode == 2) ? (pl & mask) : ((dout_mode == 1) ? mask : 32'd0);
      e.is_abort = (mode == 2);
      e.bits     = pl & mask;
      e.pulses   = n;
      e.hi       = n * h;
      e.ld       = h;
      if (mode == 2) begin
         e.busy_len = ab_len;
         e.status   = {32'd0, 16'd0, exp_txn, 8'h04};
      end else begin
         exp_txn    = exp_txn + 8'd1;
         e.busy_len = (2 * n + 1) * h;
         e.status   = {cap, 16'd0, exp_txn, 8'h02};
      end
      if (mode != 3) sb_q.push_back(e);
      if (mode == 1) begin
         @(negedge clk);
         cfg_word[1] = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (busy && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check_eq("busy_timeout", 64'(busy), 64'd0);
      cfg_word[0] = 1'b0;
      cfg_word[1] = 1'b0;
   endtask

   task automatic wait_busy();
      int n = 0;
      @(negedge clk);
      while (!busy && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check_eq("start_timeout", 64'(busy), 64'd1);
   endtask

   // Monitor: measure each busy window and compare it against the queued expectation.
   logic        prev_busy = 1'b0;
   logic        prev_clk = 1'b0;
   int          m_busy = 0, m_pulses = 0, m_hi = 0, m_ld = 0;
   logic [31:0] m_bits = '0;

   always @(negedge clk) begin
      exp_t e;
      if (busy && !prev_busy) begin
         m_busy = 0; m_pulses = 0; m_hi = 0; m_ld = 0; m_bits = '0;
      end
      if (busy) m_busy++;
      if (scan_clk && !prev_clk) begin
         m_bits = {m_bits[30:0], scan_din};
         m_pulses++;
      end
      if (scan_clk) m_hi++;
      if (scan_load) m_ld++;
      if (!busy && prev_busy && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("busy_len", 64'(m_busy), 64'(e.busy_len));
         if (e.is_abort) begin
            check_eq("abort_outs", {61'd0, scan_clk, scan_din, scan_load}, 64'd0);
            check_eq("abort_status", 64'(status_word[31:0]), e.status);
         end else begin
            check_eq("din_bits", 64'(m_bits), 64'(e.bits));
            check_eq("clk_pulses", 64'(m_pulses), 64'(e.pulses));
            check_eq("clk_hi_cycles", 64'(m_hi), 64'(e.hi));
            check_eq("load_cycles", 64'(m_ld), 64'(e.ld));
            check_eq("status", status_word, e.status);
         end
      end
      prev_busy = busy;
      prev_clk  = scan_clk;
   end

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      check_eq("rst_status", status_word, 64'd0);
      check_eq("rst_outs", {60'd0, busy, scan_clk, scan_din, scan_load}, 64'd0);
      rstn = 1'b1;

      // basic shift: 0xA, N=4, DIV=0, scan_dout tied 1
      dout_mode = 1;
      start_txn(32'hA, 5'd3, 8'd0, 0, 0);
      wait_done();
      check_eq("basic_status", status_word, 64'h0000000F_00000102);

      // divider: N=1, DIV=3
      dout_mode = 0;
      start_txn(32'h1, 5'd0, 8'd3, 0, 0);
      wait_done();

      for (int i = 0; i < 6; i++) begin
         dout_mode = int'($urandom_range(0, 2));
         start_txn($urandom, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 2)), 0, 0);
         wait_done();
      end

      dout_mode = 2;
      start_txn(32'h12345678, 5'd31, 8'd0, 0, 0);
      wait_done();
      check_eq("loop_capture", 64'(status_word[63:32]), 64'h12345678);

      // start retoggled and cfg changed mid-run
      start_txn(32'h000000C3, 5'd7, 8'd1, 0, 0);
      repeat (5) @(negedge clk);
      cfg_word = {32'hFFFF0000, 11'd0, 5'd20, 8'd5, 6'd0, 1'b0, 1'b0};
      @(negedge clk); cfg_word[0] = 1'b1;
      @(negedge clk); cfg_word[0] = 1'b0;
      @(negedge clk); cfg_word[0] = 1'b1;
      wait_done();

      // abort together with start in IDLE is ignored
      start_txn(32'h5, 5'd2, 8'd0, 1, 0);
      wait_done();

      // abort at busy cycle 10
      start_txn(32'hDEADBEEF, 5'd31, 8'd0, 2, 10);
      wait_busy();
      repeat (9) @(negedge clk);
      cfg_word[1] = 1'b1;
      wait_done();

      // abort coinciding with the final LOAD cycle
      start_txn(32'h1, 5'd0, 8'd0, 2, 3);
      wait_busy();
      repeat (2) @(negedge clk);
      cfg_word[1] = 1'b1;
      wait_done();
      check_eq("abort_load_txn", 64'(status_word[15:8]), 64'(exp_txn));

      // reset mid-shift
      start_txn(32'hCAFEF00D, 5'd31, 8'd2, 3, 0);
      repeat (20) @(negedge clk);
      rstn = 1'b0;
      cfg_word = 64'd1;
      @(negedge clk);
      check_eq("rst_mid_status", status_word, 64'd0);
      check_eq("rst_mid_outs", {60'd0, busy, scan_clk, scan_din, scan_load}, 64'd0);
      exp_txn = '0;
      // start held high through reset release
      rstn = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= busy;
      end
      check_eq("held_no_start", 64'(seen), 64'd0);
      dout_mode = 1;
      start_txn(32'h3, 5'd1, 8'd0, 0, 0);
      wait_done();

      // wrap after 256 completed transactions
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_txn = '0;
      for (int i = 0; i < 256; i++) begin
         start_txn($urandom, 5'd0, 8'd0, 0, 0);
         wait_done();
      end
      check_eq("wrap_txn", 64'(status_word[15:8]), 64'd0);

      repeat (2) @(negedge clk);
      check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
